// File: rtl/arbitro_gerenciador_ativos_pkg.sv
// Shared definitions for the active-node manager arbiter: FSM state encodings and op codes.
package arbitro_gerenciador_ativos_pkg;

    localparam int STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE      = 3'd0,
        ST_EMITIR    = 3'd1,
        ST_AGUARDAR  = 3'd2,
        ST_RESPONDER = 3'd3,
        ST_PAUSA     = 3'd4
    } state_t;

    localparam logic OP_DESATIVAR = 1'b0;
    localparam logic OP_ATUALIZAR = 1'b1;

endpackage

// File: rtl/arbitro_gerenciador_ativos_rr.sv
// Combinational round-robin search: first set request strictly after ptr, wrapping.
module arbitro_rr
    import arbitro_gerenciador_ativos_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int REQ_IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]       req,
    input  logic [REQ_IDX_WIDTH-1:0] ptr,
    output logic [REQ_IDX_WIDTH-1:0] grant,
    output logic                     any_req
);

    logic [REQ_IDX_WIDTH-1:0] cand;

    // i runs to NUM_REQ so the pointer itself is the last candidate searched.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = REQ_IDX_WIDTH'((int'(ptr) + i) % NUM_REQ);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                grant   = cand;
            end
        end
    end

endmodule

// File: rtl/arbitro_gerenciador_ativos.sv
// Round-robin sharing of the active-node manager request port among NUM_REQ requesters.
// Optional wait timeout in ST_AGUARDAR is enabled with the ARBITRO_TIMEOUT_EN macro.
module arbitro_gerenciador_ativos
    import arbitro_gerenciador_ativos_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int REQ_IDX_WIDTH  = 2,
    parameter int NUM_NA         = 8,
    parameter int ADR_WIDTH      = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid_in,
    input  logic [NUM_REQ-1:0]           req_op_in,
    input  logic [NUM_REQ*ADR_WIDTH-1:0] req_endereco_in,
    output logic [NUM_REQ-1:0]           resp_valid_out,
    output logic [NUM_NA-1:0]            resp_habilitar_out,
    output logic                         resp_erro_out,
    output logic                         desativar_out,
    output logic                         atualizar_out,
    output logic [ADR_WIDTH-1:0]         endereco_out,
    input  logic [NUM_NA-1:0]            habilitar_in,
    output logic                         ocupado_out
);

    state_t                   state_q, state_d;
    logic [REQ_IDX_WIDTH-1:0] rr_ptr_q, grant_q, rr_grant;
    logic                     rr_any;
    logic                     op_q;
    logic [ADR_WIDTH-1:0]     endereco_q;
    logic [NUM_NA-1:0]        hab_q;
    logic                     load_grant, capture;
    logic [ADR_WIDTH-1:0]     req_adr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_adr
        assign req_adr[g] = req_endereco_in[ADR_WIDTH*g +: ADR_WIDTH];
    end

    arbitro_rr #(
        .NUM_REQ       (NUM_REQ),
        .REQ_IDX_WIDTH (REQ_IDX_WIDTH)
    ) u_rr (
        .req     (req_valid_in),
        .ptr     (rr_ptr_q),
        .grant   (rr_grant),
        .any_req (rr_any)
    );

`ifdef ARBITRO_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             erro_q;
    logic             timeout;
`endif

    always_comb begin
        state_d    = state_q;
        load_grant = 1'b0;
        capture    = 1'b0;
`ifdef ARBITRO_TIMEOUT_EN
        timeout    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    load_grant = 1'b1;
                    state_d    = ST_EMITIR;
                end
            end
            ST_EMITIR:   state_d = ST_AGUARDAR;
            ST_AGUARDAR: begin
                // A response arriving on the timeout cycle still wins.
                if (habilitar_in != '0) begin
                    capture = 1'b1;
                    state_d = ST_RESPONDER;
                end
`ifdef ARBITRO_TIMEOUT_EN
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout = 1'b1;
                    state_d = ST_RESPONDER;
                end
`endif
            end
            ST_RESPONDER: state_d = ST_PAUSA;
            ST_PAUSA:     state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= REQ_IDX_WIDTH'(NUM_REQ - 1);
            grant_q    <= '0;
            op_q       <= OP_DESATIVAR;
            endereco_q <= '0;
            hab_q      <= '0;
        end else begin
            if (load_grant) begin
                rr_ptr_q   <= rr_grant;
                grant_q    <= rr_grant;
                op_q       <= req_op_in[rr_grant];
                endereco_q <= req_adr[rr_grant];
            end
            if (capture) begin
                hab_q <= habilitar_in;
            end
`ifdef ARBITRO_TIMEOUT_EN
            else if (timeout) begin
                hab_q <= '0;
            end
`endif
        end
    end

`ifdef ARBITRO_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            erro_q     <= 1'b0;
        end else begin
            if (state_q == ST_EMITIR) begin
                wait_cnt_q <= '0;
            end else if (state_q == ST_AGUARDAR) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (capture) begin
                erro_q <= 1'b0;
            end else if (timeout) begin
                erro_q <= 1'b1;
            end
        end
    end
`endif

    // Every output is a decode of registers; nothing passes straight from an input.
    always_comb begin
        resp_valid_out     = '0;
        resp_habilitar_out = '0;
        resp_erro_out      = 1'b0;
        desativar_out      = (state_q == ST_EMITIR) && (op_q == OP_DESATIVAR);
        atualizar_out      = (state_q == ST_EMITIR) && (op_q == OP_ATUALIZAR);
        endereco_out       = endereco_q;
        ocupado_out        = (state_q != ST_IDLE);
        if (state_q == ST_RESPONDER) begin
            resp_valid_out[grant_q] = 1'b1;
            resp_habilitar_out      = hab_q;
`ifdef ARBITRO_TIMEOUT_EN
            resp_erro_out           = erro_q;
`endif
        end
    end

endmodule

// File: doc/arbitro_gerenciador_ativos.md
Name: arbitro_gerenciador_ativos

Overview:
- Shares the single request port of the active-node manager (desativar/atualizar + endereco, one-hot habilitar response) among NUM_REQ requesters.
- Round-robin arbitration; exactly one operation outstanding at a time.
- Holds the address stable while the manager searches, captures the one-hot habilitar response and routes it back to the granted requester.
- Includes an optional timeout for operations that never complete.

Parameters:
- NUM_REQ, 4, number of requesters.
- REQ_IDX_WIDTH, 2, width of a requester index; must satisfy 2^REQ_IDX_WIDTH >= NUM_REQ.
- NUM_NA, 8, number of active-node slots (width of habilitar).
- ADR_WIDTH, 5, node address width.
- TIMEOUT_CYCLES, 64, maximum wait in ST_AGUARDAR; only used with ARBITRO_TIMEOUT_EN; must be >= 4.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_in  in  NUM_REQ  per-requester request; held high until that requester's resp_valid_out pulse
- req_op_in  in  NUM_REQ  per-requester op: 1 = atualizar, 0 = desativar; stable while req_valid_in is high
- req_endereco_in  in  NUM_REQ*ADR_WIDTH  packed addresses; requester i occupies bits [ADR_WIDTH*i +: ADR_WIDTH]
- resp_valid_out  out  NUM_REQ  one-cycle one-hot completion pulse to the granted requester
- resp_habilitar_out  out  NUM_NA  captured one-hot slot; valid only while any resp_valid_out bit is high
- resp_erro_out  out  1  timeout flag, qualified by resp_valid_out
- desativar_out  out  1  one-cycle pulse to manager desativar_in
- atualizar_out  out  1  one-cycle pulse to manager atualizar_in
- endereco_out  out  ADR_WIDTH  to manager endereco_in
- habilitar_in  in  NUM_NA  from manager habilitar_out
- ocupado_out  out  1  high in every state except ST_IDLE

Behaviour:
- Reset:
  - state = ST_IDLE; rr pointer = NUM_REQ-1, so requester 0 wins first.
  - All outputs 0; grant index and captured habilitar = 0.
- All outputs decode from registered state, grant and capture registers; no combinational input-to-output path.
- ST_IDLE:
  - If any req_valid_in bit is high, pick the first set bit searching upward from pointer+1, wrapping.
  - Register the grant index, op and address, and set pointer = grant; next state ST_EMITIR.
  - If no request is pending, stay in ST_IDLE.
- ST_EMITIR (1 cycle):
  - desativar_out = !op or atualizar_out = op (one pulse only).
  - endereco_out = latched address; next state ST_AGUARDAR.
- ST_AGUARDAR:
  - endereco_out is held at the latched value, because the manager compares it combinationally every cycle.
  - When habilitar_in != 0, capture it into the response register; next state ST_RESPONDER.
  - If habilitar_in is multi-hot, capture it unchanged; no correction is applied.
- ST_RESPONDER (1 cycle):
  - resp_valid_out[grant] = 1; resp_habilitar_out = captured value; resp_erro_out as set by the timeout logic.
  - Next state ST_PAUSA.
- ST_PAUSA (1 cycle):
  - Guarantees the manager has returned to idle and habilitar_in has dropped before the next pulse.
  - Next state ST_IDLE.
- Minimum request-to-response latency is 4 cycles after the grant: EMITIR, >=2 in AGUARDAR, RESPONDER.
- Back-to-back throughput is at most one operation per 6 cycles.
- Requester deasserts req_valid_in mid-operation: the operation still completes and the response pulse is still issued, even though the requester has deasserted its request. The requester is not re-granted unless it asserts req_valid_in again.
- Requester keeps req_valid_in high on the cycle after its response: this is treated as a new request and arbitrated normally. Since pointer = that requester, the other requesters are served first.
- Reset mid-operation:
  - Immediate return to ST_IDLE with all outputs 0.
  - The in-flight request is dropped with no response.
- endereco_out keeps its last value in ST_IDLE; it is 0 after reset.

Optional Feature:
- Macro ARBITRO_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ST_AGUARDAR and increments each cycle there.
  - If it reaches TIMEOUT_CYCLES-1 with habilitar_in still 0, go to ST_RESPONDER with captured habilitar = 0 and resp_erro_out = 1.
  - A non-zero habilitar_in on that same cycle takes priority: normal response, erro = 0.
- Undefined:
  - No counter exists; ST_AGUARDAR waits indefinitely.
  - resp_erro_out is tied to 0.

Decomposition:
- Shared package:
  - state encodings ST_IDLE/ST_EMITIR/ST_AGUARDAR/ST_RESPONDER/ST_PAUSA (STATE_WIDTH = 3)
  - op codes OP_DESATIVAR = 0, OP_ATUALIZAR = 1
- One sub-module, arbitro_rr:
  - Combinational round-robin search: request vector + pointer -> grant index + any_req.
  - The pointer register remains in the parent.

Test Plan:
- Single atualizar: req 2 with addr 0x0A; manager model returns habilitar = 8'b0000_0100 three cycles after the pulse. Required:
  - one atualizar_out pulse
  - endereco_out = 0x0A held until ST_RESPONDER
  - resp_valid_out = 4'b0100 for one cycle with resp_habilitar_out = 8'h04 and erro = 0
- Fairness: req 0, 1 and 3 asserted together and held. Required grant order 0, 1, 3, then 0, 1, 3 again; each op begins exactly 6 cycles after the previous one when the manager responds in the minimum time.
- Desativar miss with ARBITRO_TIMEOUT_EN and TIMEOUT_CYCLES = 8; habilitar_in stays 0. Required: response after exactly 8 AGUARDAR cycles with habilitar = 0 and erro = 1; without the macro, the block remains in ST_AGUARDAR and ocupado_out = 1.
- Withdrawn request: req 1 drops req_valid_in during ST_AGUARDAR. Required: resp_valid_out[1] still pulses, followed by ST_PAUSA and ST_IDLE with no re-grant.
- Reset mid-operation: assert rst_n = 0 in ST_AGUARDAR. Required: all outputs 0 asynchronously and no response pulse; after release, pending req 0 is granted first.
- Continuous requester: req 3 alone, held high. Required: re-granted after each ST_PAUSA, with one response per 6 cycles when the manager responds in the minimum time.
